// File: rtl/mmio_seven_seg_controller.sv
// mmio_seven_seg_controller
//   Byte-wide memory-mapped seven-segment display controller. Holds one
//   pattern register per digit plus CTRL and ENMASK, drives every digit in
//   parallel on seg and also time-multiplexes them onto scan_seg/scan_an.
//
//   Register map (byte offsets from BASE_ADDR):
//     0 .. NUM_DIGITS-1 : digit pattern i (glyph-encoded unless CTRL.RAW)
//     NUM_DIGITS        : CTRL   bit0 RAW, bit1 BLANK, bit2 BLINK_EN
//     NUM_DIGITS+1      : ENMASK bit i enables digit i
//   Any other address is write-ignored and reads as 8'h00.
//
//   Ports:
//     clk, nrst      : rising-edge clock, asynchronous active-low reset
//     addr/wdata/we  : write port, committed on the clk edge where we=1
//     re             : read strobe; rdata/rvalid answer one cycle later
//     seg            : parallel patterns, digit i at [8i+7:8i] (bit7 = dp)
//     scan_seg       : pattern of the digit currently scanned
//     scan_an        : one-hot active-high select of the scanned digit
//
//   Bus handshake: there is no back-pressure. A write is taken on every edge
//   with we=1; a read issued with re=1 always returns exactly one cycle later
//   with rvalid=1 for that single cycle. A read and write to the same
//   address in the same cycle return the value held before the write.
module mmio_seven_seg_controller #(
  parameter int          NUM_DIGITS = 8,
  parameter logic [15:0] BASE_ADDR  = 16'h0000,
  parameter int          SCAN_DIV   = 1000,
  parameter int          BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [15:0]             addr,
  input  logic [7:0]              wdata,
  input  logic                    we,
  input  logic                    re,
  output logic [7:0]              rdata,
  output logic                    rvalid,
  output logic [8*NUM_DIGITS-1:0] seg,
  output logic [7:0]              scan_seg,
  output logic [NUM_DIGITS-1:0]   scan_an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Character generator for non-raw digit writes.
  function automatic logic [7:0] glyph(input logic [7:0] code);
    logic [7:0] g;
    case (code)
      8'd0:    g = 8'h3F;
      8'd1:    g = 8'h06;
      8'd2:    g = 8'h5B;
      8'd3:    g = 8'h4F;
      8'd4:    g = 8'h66;
      8'd5:    g = 8'h6D;
      8'd6:    g = 8'h7D;
      8'd7:    g = 8'h07;
      8'd8:    g = 8'h7F;
      8'd9:    g = 8'h6F;
      8'd10:   g = 8'h77;
      8'd11:   g = 8'h7C;
      8'd12:   g = 8'h39;
      8'd13:   g = 8'h5E;
      8'd14:   g = 8'h79;
      8'd15:   g = 8'h71;
      8'd16:   g = 8'h76;  // H
      8'd17:   g = 8'h3E;  // U
      8'd18:   g = 8'h5C;  // o
      8'd19:   g = 8'h50;  // r
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  // State
  logic [7:0]              digit_q [NUM_DIGITS];
  logic [7:0]              digit_d [NUM_DIGITS];
  logic [2:0]              ctrl_q, ctrl_d;
  logic [NUM_DIGITS-1:0]   enmask_q, enmask_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           scan_idx_q, scan_idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
  logic [7:0]              scan_seg_q, scan_seg_d;
  logic [NUM_DIGITS-1:0]   scan_an_q, scan_an_d;
  logic [7:0]              rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;

  // Address decode. The subtraction is one bit wider so addresses below
  // BASE_ADDR show up as negative and never alias onto the map.
  logic [16:0]   off;
  logic          in_map;
  logic          is_digit, is_ctrl, is_mask;
  logic [IW-1:0] widx;

  assign off      = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_map   = !off[16];
  assign is_digit = in_map && (off[15:0] < 16'(NUM_DIGITS));
  assign is_ctrl  = in_map && (off[15:0] == 16'(NUM_DIGITS));
  assign is_mask  = in_map && (off[15:0] == 16'(NUM_DIGITS + 1));
  assign widx     = off[IW-1:0];

  logic presc_term, idx_term, blink_term;
  assign presc_term = (presc_q == PW'(SCAN_DIV - 1));
  assign idx_term   = (scan_idx_q == IW'(NUM_DIGITS - 1));
  assign blink_term = (blink_cnt_q == BW'(BLINK_DIV - 1));

  logic [NUM_DIGITS-1:0] vis;
  logic [7:0]            rd_val;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) digit_d[i] = digit_q[i];
    ctrl_d      = ctrl_q;
    enmask_d    = enmask_q;
    presc_d     = presc_q;
    scan_idx_d  = scan_idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    seg_d       = '0;
    scan_seg_d  = 8'h00;
    scan_an_d   = '0;
    rd_val      = 8'h00;

    // Register writes. The mode bit used is the one held before this write,
    // so changing RAW only affects later digit writes.
    if (we) begin
      if (is_digit) digit_d[widx] = ctrl_q[0] ? wdata : glyph(wdata);
      if (is_ctrl)  ctrl_d = wdata[2:0];
      if (is_mask)  enmask_d = wdata[NUM_DIGITS-1:0];
    end

    // Scan prescaler -> scan index -> blink counter -> blink phase.
    if (presc_term) begin
      presc_d = '0;
      if (idx_term) begin
        scan_idx_d = '0;
        if (blink_term) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end else begin
        scan_idx_d = scan_idx_q + 1'b1;
      end
    end else begin
      presc_d = presc_q + 1'b1;
    end

    // Turning blink off restarts the next blink cycle in the visible phase.
    if (we && is_ctrl && !wdata[2]) phase_d = 1'b0;

    // Display outputs from the current (pre-edge) state.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      vis[i] = enmask_q[i] && !ctrl_q[1] && !(ctrl_q[2] && phase_q);
      seg_d[8*i +: 8] = vis[i] ? digit_q[i] : 8'h00;
    end
    if (vis[scan_idx_q]) begin
      scan_an_d[scan_idx_q] = 1'b1;
      scan_seg_d            = digit_q[scan_idx_q];
    end

    // Read path uses pre-write state.
    if (is_digit)     rd_val = digit_q[widx];
    else if (is_ctrl) rd_val = {5'b0, ctrl_q};
    else if (is_mask) rd_val = 8'(enmask_q);
    rdata_d  = re ? rd_val : 8'h00;
    rvalid_d = re;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 8'h00;
      ctrl_q      <= 3'b000;
      enmask_q    <= '1;
      presc_q     <= '0;
      scan_idx_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      seg_q       <= '0;
      scan_seg_q  <= 8'h00;
      scan_an_q   <= '0;
      rdata_q     <= 8'h00;
      rvalid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
      ctrl_q      <= ctrl_d;
      enmask_q    <= enmask_d;
      presc_q     <= presc_d;
      scan_idx_q  <= scan_idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      scan_seg_q  <= scan_seg_d;
      scan_an_q   <= scan_an_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign seg      = seg_q;
  assign scan_seg = scan_seg_q;
  assign scan_an  = scan_an_q;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_mmio_seven_seg_controller.sv
// Bench for mmio_seven_seg_controller: 8 digits at BASE 16'h0100,
// SCAN_DIV=4, BLINK_DIV=2 (blink phase toggles every 4*8*2 = 64 cycles).
module tb_mmio_seven_seg_controller;

  localparam int          ND    = 8;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          SDIV  = 4;
  localparam int          BDIV  = 2;
  localparam int          BLINK_PERIOD = SDIV * ND * BDIV;

  // Clock / reset
  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [15:0]   addr = 16'h0000;
  logic [7:0]    wdata = 8'h00;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [7:0]    rdata;
  logic          rvalid;
  logic [8*ND-1:0] seg;
  logic [7:0]    scan_seg;
  logic [ND-1:0] scan_an;

  always #5 clk = ~clk;

  mmio_seven_seg_controller #(
    .NUM_DIGITS(ND), .BASE_ADDR(BASE), .SCAN_DIV(SDIV), .BLINK_DIV(BDIV)
  ) dut (
    .clk(clk), .nrst(nrst), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .seg(seg), .scan_seg(scan_seg),
    .scan_an(scan_an)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model of the register file
  logic [7:0] m_digit [ND];
  logic [2:0] m_ctrl;
  logic [7:0] m_mask;

  function automatic logic [7:0] ref_glyph(input logic [7:0] c);
    logic [7:0] t [20];
    t = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71,
          8'h76, 8'h3E, 8'h5C, 8'h50};
    return (c < 8'd20) ? t[c] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_digit[i] = 8'h00;
    m_ctrl = 3'b000;
    m_mask = 8'hFF;
  endtask

  function automatic int offset_of(input logic [15:0] a);
    return (a < BASE) ? -1 : int'(a - BASE);
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    int o;
    o = offset_of(a);
    if (o >= 0 && o < ND) m_digit[o] = m_ctrl[0] ? d : ref_glyph(d);
    else if (o == ND)     m_ctrl = d[2:0];
    else if (o == ND + 1) m_mask = d;
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    int o;
    o = offset_of(a);
    if (o >= 0 && o < ND) return m_digit[o];
    if (o == ND)          return {5'b0, m_ctrl};
    if (o == ND + 1)      return m_mask;
    return 8'h00;
  endfunction

  // Expected parallel output, assuming the blink phase is visible.
  function automatic logic [63:0] model_seg();
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < ND; i++)
      if (m_mask[i] && !m_ctrl[1]) s[8*i +: 8] = m_digit[i];
    return s;
  endfunction

  // Driver tasks
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [15:0] a);
    @(negedge clk);
    addr = a; re = 1'b1;
    exp_q.push_back(model_read(a));
    @(negedge clk);
    re = 1'b0;
    check_eq("rvalid_latency", {63'b0, rvalid}, 64'd1);
  endtask

  task automatic bus_rw(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1'b1; re = 1'b1;
    exp_q.push_back(model_read(a));
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    model_write(a, d);
    check_eq("rw_rvalid", {63'b0, rvalid}, 64'd1);
  endtask

  // seg is registered one cycle after the state it reflects.
  task automatic check_seg(input string tag);
    @(negedge clk);
    check_eq(tag, seg, model_seg());
  endtask

  // Read-data monitor
  always @(negedge clk) begin
    if (nrst === 1'b1 && rvalid === 1'b1) begin
      if (exp_q.size() == 0) check_eq("rvalid_unexpected", 64'd1, 64'd0);
      else check_eq("rdata", {56'b0, rdata}, {56'b0, exp_q.pop_front()});
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_seg"}, seg, 64'd0);
    check_eq({tag, "_scan"}, {48'b0, scan_an, scan_seg}, 64'd0);
    check_eq({tag, "_rd"}, {55'b0, rvalid, rdata}, 64'd0);
  endtask

  initial begin
    logic [7:0] codes [8];
    logic [7:0] prev_an, prev_sg;
    bit found;
    int k;

    // Reset
    model_reset();
    #1;
    check_outputs_zero("reset_async");
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_held");
    nrst = 1'b1;

    // Glyph write: digit 2 gets '3'
    bus_write(BASE + 16'd2, 8'd3);
    @(negedge clk);
    check_eq("d2_glyph3", seg, 64'h0000_0000_004F_0000);

    // More glyph codes, including the letter range and the out-of-table range
    codes = '{8'h10, 8'h13, 8'h03, 8'h0A, 8'h14, 8'hFF, 8'h11, 8'h12};
    for (int i = 0; i < ND; i++) if (i != 2) bus_write(BASE + 16'(i), codes[i]);
    check_seg("seg_glyphs");
    for (int i = 0; i < ND; i++) bus_read(BASE + 16'(i));

    // RAW mode; CTRL upper bits are not stored
    bus_write(BASE + 16'(ND), 8'hF9);
    bus_read(BASE + 16'(ND));
    bus_write(BASE, 8'hA5);
    @(negedge clk);
    check_eq("raw_d0", {56'b0, seg[7:0]}, 64'hA5);
    bus_read(BASE);

    // Leaving RAW does not touch stored patterns
    bus_write(BASE + 16'(ND), 8'h00);
    bus_read(BASE);
    bus_write(BASE + 16'd1, 8'h02);
    check_seg("seg_after_raw");

    // Same-cycle read/write returns the old value
    bus_rw(BASE + 16'd1, 8'h05);
    bus_read(BASE + 16'd1);

    // Unmapped addresses: writes ignored, reads zero
    bus_write(BASE + 16'(ND + 2), 8'h55);
    bus_write(BASE - 16'd1, 8'h55);
    bus_read(BASE + 16'(ND + 2));
    bus_read(BASE - 16'd1);
    bus_read(BASE + 16'(ND + 1));
    check_seg("seg_unmapped");

    // Scan stepping: wait for entry into index 0, then every SDIV cycles
    prev_an = scan_an;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (scan_an == 8'h01 && prev_an != 8'h01) found = 1;
      prev_an = scan_an;
    end
    check_eq("scan_sync", {63'b0, found}, 64'd1);
    for (k = 1; k <= SDIV * (ND + 1); k++) begin
      @(negedge clk);
      if (found && (k % SDIV) == 0) begin
        check_eq("scan_an", {56'b0, scan_an}, 64'd1 << ((k / SDIV) % ND));
        check_eq("scan_seg", {56'b0, scan_seg}, {56'b0, m_digit[(k / SDIV) % ND]});
      end
    end

    // Masked digit 0: nothing selected during its scan slot
    bus_write(BASE + 16'(ND + 1), 8'hFE);
    check_seg("seg_mask_fe");
    prev_an = scan_an; prev_sg = scan_seg;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (scan_an == 8'h02 && prev_an != 8'h02) found = 1;
      else begin prev_an = scan_an; prev_sg = scan_seg; end
    end
    check_eq("mask_sync", {63'b0, found}, 64'd1);
    check_eq("mask_slot0", {48'b0, prev_an, prev_sg}, 64'd0);
    check_eq("mask_slot1_seg", {56'b0, scan_seg}, {56'b0, m_digit[1]});
    bus_write(BASE + 16'(ND + 1), 8'hFF);

    // Blink: find a visible -> dark edge, then check the period
    bus_write(BASE + 16'(ND), 8'h04);
    found = 0;
    prev_sg = seg[7:0];
    for (int c = 0; c < 4 * BLINK_PERIOD && !found; c++) begin
      @(negedge clk);
      if (seg[7:0] == 8'h00 && prev_sg == 8'hA5) found = 1;
      prev_sg = seg[7:0];
    end
    check_eq("blink_sync", {63'b0, found}, 64'd1);
    for (k = 1; k <= 2 * BLINK_PERIOD; k++) begin
      @(negedge clk);
      if (found && (k == BLINK_PERIOD - 1 || k == 2 * BLINK_PERIOD))
        check_eq("blink_dark", {56'b0, seg[7:0]}, 64'h00);
      if (found && (k == BLINK_PERIOD || k == 2 * BLINK_PERIOD - 1))
        check_eq("blink_lit", {56'b0, seg[7:0]}, 64'hA5);
    end
    // Phase is dark here; disabling blink must reset it to the lit phase
    bus_write(BASE + 16'(ND), 8'h00);
    bus_write(BASE + 16'(ND), 8'h04);
    check_seg("blink_phase_clear");
    bus_write(BASE + 16'(ND), 8'h00);

    // BLANK
    bus_write(BASE + 16'(ND), 8'h02);
    check_seg("seg_blank");
    repeat (SDIV * ND) @(negedge clk);
    check_eq("scan_blank", {48'b0, scan_an, scan_seg}, 64'd0);
    bus_write(BASE + 16'(ND), 8'h00);
    bus_write(BASE + 16'(ND + 1), 8'h0F);

    // Reset mid-scan with a read in flight
    @(negedge clk);
    addr = BASE; re = 1'b1;
    #2;
    nrst = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    re = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("rvalid_after_reset", {63'b0, rvalid}, 64'd0);
    end
    bus_read(BASE + 16'(ND + 1));
    bus_read(BASE + 16'(ND));
    bus_read(BASE);
    check_seg("seg_after_reset");

    @(negedge clk);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_seven_seg_controller.md
MMIO_SEVEN_SEG_CONTROLLER -- requirements
Module: mmio_seven_seg_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 8, number of display digits, legal range 1..8.
REQ-002 SHALL have parameter BASE_ADDR, default 16'h0000, first byte address of the register map.
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clk cycles per scan step, minimum 1.
REQ-004 SHALL have parameter BLINK_DIV, default 64, scan-index wraps per blink phase toggle, minimum 1.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port addr, input, 16, bus byte address.
REQ-008 SHALL have port wdata, input, 8, write data.
REQ-009 SHALL have port we, input, 1, write strobe, sampled each clk.
REQ-010 SHALL have port re, input, 1, read strobe, sampled each clk.
REQ-011 SHALL have port rdata, output, 8, read data.
REQ-012 SHALL have port rvalid, output, 1, read data valid.
REQ-013 SHALL have port seg, output, 8*NUM_DIGITS, parallel segment patterns, digit i at bits [8i+7:8i], bit0=a..bit6=g, bit7=dp.
REQ-014 SHALL have port scan_seg, output, 8, multiplexed segment pattern.
REQ-015 SHALL have port scan_an, output, NUM_DIGITS, one-hot active-high digit select.

Function
REQ-016 SHALL map BASE_ADDR+i (0<=i<NUM_DIGITS) to digit register i, BASE_ADDR+NUM_DIGITS to CTRL, BASE_ADDR+NUM_DIGITS+1 to ENMASK; all other addresses are ignored on write and return 8'h00 on read.
REQ-017 SHALL define CTRL bit0 RAW, bit1 BLANK, bit2 BLINK_EN; bits 7:3 read as 0 and ignore writes.
REQ-018 SHALL, on a digit write with RAW=0, store the glyph of wdata: 0-F hex, 16 H(8'h76), 17 U(8'h3E), 18 o(8'h5C), 19 r(8'h50), 20-255 8'h00.
REQ-019 SHALL, on a digit write with RAW=1, store wdata unmodified.
REQ-020 SHALL commit a write on the clk edge where we=1; the new value SHALL be visible on seg the following cycle.
REQ-021 SHALL return the stored register value on rdata with rvalid=1 exactly one cycle after re=1; otherwise rvalid=0 and rdata=8'h00.
REQ-022 SHALL, when we and re target the same address in the same cycle, return the pre-write value.
REQ-023 SHALL use ENMASK bit i to enable digit i; bits >= NUM_DIGITS read as 0.
REQ-024 SHALL count prescaler 0..SCAN_DIV-1 and, on terminal count, advance scan index 0..NUM_DIGITS-1, wrapping to 0.
REQ-025 SHALL count scan-index wraps 0..BLINK_DIV-1 and, on terminal count, toggle blink phase.
REQ-026 SHALL define digit i visible iff ENMASK[i]=1 and BLANK=0 and not (BLINK_EN=1 and phase=1).
REQ-027 SHALL drive seg digit i with the stored pattern when visible, else 8'h00.
REQ-028 SHALL drive scan_an with bit index set and scan_seg with that digit's pattern when visible, else scan_an and scan_seg all zero.
REQ-029 SHALL register seg, scan_seg and scan_an (one-cycle latency from state change).
REQ-030 SHALL clear blink phase to 0 when BLINK_EN is written 0; the counters SHALL keep running.
REQ-031 SHALL not alter stored digit patterns when RAW changes; mode applies only to subsequent writes.

Reset
REQ-032 SHALL, while nrst=0, reset digit registers to 8'h00, CTRL to 8'h00, ENMASK to all ones in bits NUM_DIGITS-1:0, prescaler/scan index/blink counter/phase to 0, and seg, scan_seg, scan_an, rdata, rvalid to 0.
REQ-033 SHALL abort any in-flight read on reset; no rvalid pulse follows deassertion.

Verification
REQ-034 SHALL verify: reset, write 8'd3 to BASE_ADDR+2 -> seg[23:16]=8'h4F next cycle, others 8'h00.
REQ-035 SHALL verify: write CTRL=8'h01, write 8'hA5 to BASE_ADDR+0 -> seg[7:0]=8'hA5; read BASE_ADDR+0 -> rvalid=1, rdata=8'hA5 one cycle later.
REQ-036 SHALL verify: SCAN_DIV=4, NUM_DIGITS=8 -> scan_an steps 8'h01,8'h02..8'h80,8'h01 every 4 cycles; ENMASK=8'hFE -> scan_an/scan_seg 0 during index 0.
REQ-037 SHALL verify: SCAN_DIV=1, BLINK_DIV=2, CTRL=8'h04 -> seg toggles between pattern and 8'h00 every 16 cycles (NUM_DIGITS=8).
REQ-038 SHALL verify: simultaneous we/re same address -> old value returned; write to BASE_ADDR+NUM_DIGITS+2 -> no state change, read returns 8'h00.
REQ-039 SHALL verify: nrst asserted mid-scan with re pending -> all outputs 0 immediately, rvalid stays 0 after release, ENMASK reads all ones.
